// File: rtl/alu4_pkg.sv
// Shared opcode, condition-code, state and flag-position definitions for alu4_issue.
package alu4_pkg;

   typedef enum logic [2:0] {
      OP_NOT_A = 3'b000,
      OP_NOT_B = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_XOR   = 3'b100,
      OP_XNOR  = 3'b101,
      OP_ADD   = 3'b110,
      OP_SUB   = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      CC_AL = 3'b000,
      CC_EQ = 3'b001,
      CC_NE = 3'b010,
      CC_CS = 3'b011,
      CC_CC = 3'b100,
      CC_MI = 3'b101,
      CC_LT = 3'b110,
      CC_GE = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Flag vector layout is {N,Z,C,V}.
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu4_cond.sv
// Combinational condition-code evaluation against a {N,Z,C,V} flag vector.
module alu4_cond
   import alu4_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond,
   output logic       taken
);

   logic n, z, c, v;

   always_comb begin
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      taken = 1'b0;
      case (cond_e'(cond))
         CC_AL:   taken = 1'b1;
         CC_EQ:   taken = z;
         CC_NE:   taken = ~z;
         CC_CS:   taken = c;
         CC_CC:   taken = ~c;
         CC_MI:   taken = n;
         CC_LT:   taken = n ^ v;
         CC_GE:   taken = ~(n ^ v);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu4_issue.sv
// Issue/response wrapper around an external 4-bit ALU: registers operands on accept,
// captures result and flags after one EXEC cycle, and holds the response until taken.
module alu4_issue
   import alu4_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_op,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic       in_acc_sel,
   input  logic [2:0] in_cond,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_result,
   input  logic       alu_c,
   input  logic       alu_n,
   input  logic       alu_z,
   input  logic       alu_v,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_result,
   output logic [3:0] out_flags,
   output logic       out_cond
);

   state_e     state, state_nxt;
   logic [3:0] acc;
   logic [2:0] cond_q;
   logic [3:0] alu_flags;
   logic       exec_taken;
   logic       accept;

   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_N] = alu_n;
      alu_flags[FLAG_Z] = alu_z;
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
   end

   // Evaluated on the live ALU flags so out_cond is captured alongside them.
   alu4_cond u_cond (
      .flags (alu_flags),
      .cond  (cond_q),
      .taken (exec_taken)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = in_valid ? ST_EXEC : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         acc        <= '0;
         cond_q     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         out_result <= '0;
         out_flags  <= '0;
         out_cond   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_op <= in_op;
            alu_a  <= in_acc_sel ? acc : in_a;
            alu_b  <= in_b;
            cond_q <= in_cond;
         end
         if (state == ST_EXEC) begin
            out_result <= alu_result;
            out_flags  <= alu_flags;
            out_cond   <= exec_taken;
            acc        <= alu_result;
         end
      end
   end

endmodule

// File: tb/tb_alu4_issue.sv
// Self-checking bench for alu4_issue: behavioural ALU, transaction-level reference model,
// per-cycle compare, directed literal cases and randomized traffic.
module tb_alu4_issue;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_op = '0;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic       in_acc_sel = 1'b0;
   logic [2:0] in_cond = '0;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [3:0] alu_result;
   logic       alu_c, alu_n, alu_z, alu_v;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] out_result, out_flags;
   logic       out_cond;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu4_issue dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_acc_sel (in_acc_sel),
      .in_cond    (in_cond),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_c      (alu_c),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .alu_v      (alu_v),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .out_cond   (out_cond)
   );

   function automatic void check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endfunction

   // ALU behaviour as plain integer arithmetic; returns {N,Z,C,V,result}.
   // Logic ops pass a[0]/b[0] through C/V so flag capture is observable for every opcode.
   function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
      int ua, ub, sa, sb, r, s;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 8) ? ua - 16 : ua;
      sb = (ub >= 8) ? ub - 16 : ub;
      c  = a[0];
      v  = b[0];
      r  = 0;
      case (op)
         3'd0: r = 15 - ua;
         3'd1: r = 15 - ub;
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: r = 15 - int'(a ^ b);
         3'd6: begin
            r = (ua + ub) % 16;
            c = (ua + ub) > 15;
            s = sa + sb;
            v = (s > 7) || (s < -8);
         end
         default: begin
            r = (ua - ub + 16) % 16;
            c = ua >= ub;
            s = sa - sb;
            v = (s > 7) || (s < -8);
         end
      endcase
      return {r >= 8, r == 0, c, v, 4'(r)};
   endfunction

   function automatic logic cond_model(input logic [3:0] f, input logic [2:0] cc);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return c;
         3'd4:    return !c;
         3'd5:    return n;
         3'd6:    return n != v;
         default: return n == v;
      endcase
   endfunction

   logic [7:0] alu_word;
   always_comb alu_word = alu_model(alu_op, alu_a, alu_b);
   assign alu_result = alu_word[3:0];
   assign alu_n      = alu_word[7];
   assign alu_z      = alu_word[6];
   assign alu_c      = alu_word[5];
   assign alu_v      = alu_word[4];

   // Transaction-level reference: a request in flight, then a held response.
   logic       m_started = 1'b0;
   logic       m_exec = 1'b0, m_valid = 1'b0, m_cond = 1'b0;
   logic [3:0] m_res = '0, m_flags = '0, m_acc = '0, m_a = '0, m_b = '0;
   logic [2:0] m_op = '0, m_cc = '0;

   always @(posedge clk) begin
      logic       rdy;
      logic [7:0] r;
      if (reset) begin
         m_started = 1'b1;
         m_exec = 1'b0; m_valid = 1'b0; m_cond = 1'b0;
         m_res = '0; m_flags = '0; m_acc = '0; m_a = '0; m_b = '0; m_op = '0; m_cc = '0;
      end else if (m_started) begin
         rdy = !m_exec && (!m_valid || out_ready);
         if (m_exec) begin
            r       = alu_model(m_op, m_a, m_b);
            m_res   = r[3:0];
            m_flags = r[7:4];
            m_acc   = r[3:0];
            m_cond  = cond_model(m_flags, m_cc);
            m_exec  = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (in_valid && rdy) begin
            m_a    = in_acc_sel ? m_acc : in_a;
            m_b    = in_b;
            m_op   = in_op;
            m_cc   = in_cond;
            m_exec = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("in_ready",   int'(in_ready),   int'(!m_exec && (!m_valid || out_ready)));
         check("out_valid",  int'(out_valid),  int'(m_valid));
         check("out_result", int'(out_result), int'(m_res));
         check("out_flags",  int'(out_flags),  int'(m_flags));
         check("out_cond",   int'(out_cond),   int'(m_cond));
         check("alu_a",      int'(alu_a),      int'(m_a));
         check("alu_b",      int'(alu_b),      int'(m_b));
         check("alu_op",     int'(alu_op),     int'(m_op));
      end
   end

   // Offers a request and returns #1 after the accepting edge (inside EXEC).
   task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic sel, input logic [2:0] cc);
      int n;
      n = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc_sel = sel; in_cond = cc;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Called inside EXEC: no response yet, then the response one cycle later.
   task automatic expect_resp(input string name, input logic [3:0] ea, input logic [3:0] res,
                              input logic [3:0] fl, input logic cnd);
      @(negedge clk);
      check({name, "_exec_valid"}, int'(out_valid), 0);
      check({name, "_alu_a"},      int'(alu_a),     int'(ea));
      @(negedge clk);
      check({name, "_valid"},  int'(out_valid),  1);
      check({name, "_result"}, int'(out_result), int'(res));
      check({name, "_flags"},  int'(out_flags),  int'(fl));
      check({name, "_cond"},   int'(out_cond),   int'(cnd));
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_reset_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      issue(3'b110, 4'd7, 4'd1, 1'b0, 3'b110);
      expect_resp("add7p1_lt", 4'd7, 4'b1000, 4'b1001, 1'b0);

      issue(3'b111, 4'd3, 4'd3, 1'b0, 3'b001);
      expect_resp("sub3m3_eq", 4'd3, 4'b0000, 4'b0110, 1'b1);

      issue(3'b110, 4'd5, 4'd3, 1'b0, 3'b000);
      expect_resp("add5p3", 4'd5, 4'b1000, 4'b1001, 1'b1);
      issue(3'b110, 4'hF, 4'd8, 1'b1, 3'b000);
      expect_resp("acc_add8", 4'b1000, 4'b0000, 4'b0111, 1'b1);

      out_ready = 1'b0;
      issue(3'b100, 4'hA, 4'h6, 1'b0, 3'b010);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid",  int'(out_valid),  1);
         check("hold_ready",  int'(in_ready),   0);
         check("hold_result", int'(out_result), 12);
         check("hold_flags",  int'(out_flags),  8);
         check("hold_cond",   int'(out_cond),   1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 3'b110; in_a = 4'd1; in_b = 4'd1; in_acc_sel = 1'b0;
      in_cond = 3'b000;
      @(negedge clk);
      check("b2b_ready", int'(in_ready), 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      expect_resp("b2b_add", 4'd1, 4'd2, 4'b0000, 1'b1);

      issue(3'b110, 4'd3, 4'd4, 1'b0, 3'b000);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready",  int'(in_ready),   1);
      check("rst_result", int'(out_result), 0);
      check("rst_alu_a",  int'(alu_a),      0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_resp", int'(out_valid), 0);
      end
      @(posedge clk);
      #1;
      issue(3'b110, 4'hF, 4'd2, 1'b1, 3'b000);
      expect_resp("rst_acc_zero", 4'd0, 4'd2, 4'b0000, 1'b1);

      issue(3'b111, 4'd2, 4'd5, 1'b0, 3'b111);
      expect_resp("sub2m5_ge", 4'd2, 4'b1101, 4'b1000, 1'b0);
      issue(3'b111, 4'd2, 4'd5, 1'b0, 3'b110);
      expect_resp("sub2m5_lt", 4'd2, 4'b1101, 4'b1000, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk);
         #1;
         reset      = ($urandom_range(0, 99) == 0);
         in_valid   = ($urandom_range(0, 2) != 0);
         in_op      = 3'($urandom_range(0, 7));
         in_a       = 4'($urandom_range(0, 15));
         in_b       = 4'($urandom_range(0, 15));
         in_acc_sel = ($urandom_range(0, 1) == 1);
         in_cond    = 3'($urandom_range(0, 7));
         out_ready  = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
